// File: rtl/mmio_store_bridge_pkg.sv
// Shared types and constants for the MMIO store bridge: window base,
// entry layout and the drain FSM encoding.
package mmio_store_bridge_pkg;

    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_FF00;
    localparam int unsigned OFS_W         = 8;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned ENTRY_W       = OFS_W + DATA_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic [OFS_W-1:0]  ofs;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/mmio_store_bridge_fifo.sv
// Register-based synchronous FIFO holding queued MMIO stores; head is
// read straight from storage at the read pointer.
module m_store_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmio_store_bridge.sv
// Captures MEM-stage stores that hit the MMIO window, queues them and drains
// them over a valid/ready bus with head-of-queue timeout and drop statistics.
module mmio_store_bridge
    import mmio_store_bridge_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwriteM,
    input  logic [31:0]       aluoutM,
    input  logic [31:0]       writedataM,
    output logic              stallM,
    output logic              bus_valid,
    output logic [OFS_W-1:0]  bus_addr,
    output logic [DATA_W-1:0] bus_data,
    input  logic              bus_ready,
    output logic              err,
    input  logic              err_clr,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          hit, push, pop, xfer, drop;
    logic          full, empty;
    logic [CW-1:0] count, count_nxt;
    entry_t        head;

    assign hit       = memwriteM & (aluoutM[31:8] == MMIO_BASE[31:8]);
    // Push is judged on the start-of-cycle fill level only, so a same-cycle
    // pop never frees a slot; this keeps bus_ready out of the stallM cone.
    assign push      = hit & ~full;
    assign stallM    = hit & full;
    assign bus_valid = ~empty;
    assign xfer      = bus_valid & bus_ready;
    assign drop      = (state_q == SEND) & ~bus_ready & (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign pop       = xfer | drop;
    assign count_nxt = count + CW'(push) - CW'(pop);

    assign bus_addr  = head.ofs;
    assign bus_data  = head.data;
    assign err       = err_q;
    assign drop_cnt  = drop_cnt_q;

    m_store_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .din   ({aluoutM[7:0], writedataM}),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    always_comb begin
        state_d    = (count_nxt != '0) ? SEND : IDLE;
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
        drop_cnt_d = drop_cnt_q;
        if (pop) begin
            tmo_cnt_d = '0;
        end else if (state_q == SEND && !bus_ready) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (drop) begin
            err_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_mmio_store_bridge.sv
// Directed bench for mmio_store_bridge: a cycle table for the queue/stall
// behaviour plus hand sequences for timeout, err_clr and async reset.
module tb_mmio_store_bridge;

    logic        clk;
    logic        reset;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        stallM;
    logic        bus_valid;
    logic [7:0]  bus_addr;
    logic [31:0] bus_data;
    logic        bus_ready;
    logic        err;
    logic        err_clr;
    logic [7:0]  drop_cnt;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    mmio_store_bridge #(
        .DEPTH     (4),
        .MMIO_BASE (32'hFFFF_FF00),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .stallM     (stallM),
        .bus_valid  (bus_valid),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .bus_ready  (bus_ready),
        .err        (err),
        .err_clr    (err_clr),
        .drop_cnt   (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        mw;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic        exp_stall;
        logic        exp_valid;
        logic [7:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic mw, logic [31:0] addr, logic [31:0] data, logic rdy,
                                logic es, logic ev, logic [7:0] ea, logic [31:0] ed);
        vec_t v;
        v.mw = mw; v.addr = addr; v.data = data; v.rdy = rdy;
        v.exp_stall = es; v.exp_valid = ev; v.exp_addr = ea; v.exp_data = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        localparam logic [31:0] B = 32'hFFFF_FF00;

        memwriteM  = 1'b0;
        aluoutM    = '0;
        writedataM = '0;
        bus_ready  = 1'b0;
        err_clr    = 1'b0;
        reset      = 1'b0;

        #3;
        chk("rst_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_stall", {31'd0, stallM}, 32'd0);
        chk("rst_addr", {24'd0, bus_addr}, 32'd0);
        chk("rst_data", bus_data, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();

        //              mw    addr              data          rdy  stall valid addr   data
        // single store, drained immediately
        vecs.push_back(mk(1, 32'hFFFF_FF10, 32'hDEAD_BEEF, 1, 0, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, 32'h0,         32'h0,         1, 0, 1, 8'h10, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 32'h0,         32'h0,         1, 0, 0, 8'h00, 32'h0));
        // non-MMIO store is ignored
        vecs.push_back(mk(1, 32'h0000_0040, 32'h1234,      0, 0, 0, 8'h00, 32'h0));
        vecs.push_back(mk(0, 32'h0,         32'h0,         0, 0, 0, 8'h00, 32'h0));
        // fill to four, fifth stalls; pop doesn't free a slot the same cycle
        vecs.push_back(mk(1, B + 32'h01,    32'd1,         0, 0, 0, 8'h00, 32'h0));
        vecs.push_back(mk(1, B + 32'h02,    32'd2,         0, 0, 1, 8'h01, 32'd1));
        vecs.push_back(mk(1, B + 32'h03,    32'd3,         0, 0, 1, 8'h01, 32'd1));
        vecs.push_back(mk(1, B + 32'h04,    32'd4,         0, 0, 1, 8'h01, 32'd1));
        vecs.push_back(mk(1, B + 32'h05,    32'd5,         0, 1, 1, 8'h01, 32'd1));
        vecs.push_back(mk(1, B + 32'h05,    32'd5,         1, 1, 1, 8'h01, 32'd1));
        vecs.push_back(mk(1, B + 32'h05,    32'd5,         1, 0, 1, 8'h02, 32'd2));
        vecs.push_back(mk(0, 32'h0,         32'h0,         1, 0, 1, 8'h03, 32'd3));
        vecs.push_back(mk(0, 32'h0,         32'h0,         1, 0, 1, 8'h04, 32'd4));
        vecs.push_back(mk(0, 32'h0,         32'h0,         1, 0, 1, 8'h05, 32'd5));
        vecs.push_back(mk(0, 32'h0,         32'h0,         0, 0, 0, 8'h00, 32'h0));
        // push and pop together at count 2
        vecs.push_back(mk(1, B + 32'h20,    32'hA0,        0, 0, 0, 8'h00, 32'h0));
        vecs.push_back(mk(1, B + 32'h21,    32'hB0,        0, 0, 1, 8'h20, 32'hA0));
        vecs.push_back(mk(1, B + 32'h22,    32'hC0,        1, 0, 1, 8'h20, 32'hA0));
        vecs.push_back(mk(0, 32'h0,         32'h0,         0, 0, 1, 8'h21, 32'hB0));
        vecs.push_back(mk(0, 32'h0,         32'h0,         1, 0, 1, 8'h21, 32'hB0));
        vecs.push_back(mk(0, 32'h0,         32'h0,         1, 0, 1, 8'h22, 32'hC0));
        vecs.push_back(mk(0, 32'h0,         32'h0,         0, 0, 0, 8'h00, 32'h0));

        foreach (vecs[i]) begin
            memwriteM  = vecs[i].mw;
            aluoutM    = vecs[i].addr;
            writedataM = vecs[i].data;
            bus_ready  = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {31'd0, stallM}, {31'd0, vecs[i].exp_stall});
            chk($sformatf("v%0d_valid", i), {31'd0, bus_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_addr", i), {24'd0, bus_addr}, {24'd0, vecs[i].exp_addr});
                chk($sformatf("v%0d_data", i), bus_data, vecs[i].exp_data);
            end
            next_cycle();
        end
        memwriteM = 1'b0;
        bus_ready = 1'b0;

        // timeout: one entry left un-acked for 16 cycles
        memwriteM = 1'b1; aluoutM = B + 32'h30; writedataM = 32'hE0;
        next_cycle();
        memwriteM = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk($sformatf("tmo_valid_c%0d", c), {31'd0, bus_valid}, 32'd1);
            if (c == 16) begin
                chk("tmo_err_before", {31'd0, err}, 32'd0);
                chk("tmo_drop_before", {24'd0, drop_cnt}, 32'd0);
            end
            next_cycle();
        end
        @(negedge clk);
        chk("tmo_valid_after", {31'd0, bus_valid}, 32'd0);
        chk("tmo_err_set", {31'd0, err}, 32'd1);
        chk("tmo_drop_1", {24'd0, drop_cnt}, 32'd1);
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        @(negedge clk);
        chk("errclr_err", {31'd0, err}, 32'd0);
        chk("errclr_drop", {24'd0, drop_cnt}, 32'd1);
        next_cycle();

        // drop coinciding with err_clr: set wins
        memwriteM = 1'b1; aluoutM = B + 32'h31; writedataM = 32'hE1;
        next_cycle();
        memwriteM = 1'b0;
        err_clr   = 1'b1;
        repeat (16) next_cycle();
        err_clr = 1'b0;
        @(negedge clk);
        chk("setwins_err", {31'd0, err}, 32'd1);
        chk("setwins_drop", {24'd0, drop_cnt}, 32'd2);
        chk("setwins_valid", {31'd0, bus_valid}, 32'd0);
        next_cycle();

        // async reset with three queued entries
        for (int k = 0; k < 3; k++) begin
            memwriteM = 1'b1; aluoutM = B + 32'h41 + k; writedataM = 32'h41 + k;
            next_cycle();
        end
        memwriteM = 1'b0;
        @(negedge clk);
        chk("prerst_valid", {31'd0, bus_valid}, 32'd1);
        chk("prerst_data", bus_data, 32'h41);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus_valid}, 32'd0);
        chk("arst_addr", {24'd0, bus_addr}, 32'd0);
        chk("arst_data", bus_data, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        chk("arst_drop", {24'd0, drop_cnt}, 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        bus_ready = 1'b1;
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("postrst_valid_%0d", c), {31'd0, bus_valid}, 32'd0);
            next_cycle();
        end
        memwriteM = 1'b1; aluoutM = B + 32'h55; writedataM = 32'h5555;
        next_cycle();
        memwriteM = 1'b0;
        @(negedge clk);
        chk("postrst_new_valid", {31'd0, bus_valid}, 32'd1);
        chk("postrst_new_addr", {24'd0, bus_addr}, 32'h55);
        chk("postrst_new_data", bus_data, 32'h5555);
        next_cycle();
        @(negedge clk);
        chk("postrst_drained", {31'd0, bus_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
